// File: rtl/fork_stage.sv
`default_nettype none
// ============================================================================
// Module   : fork_stage
// Purpose  : Pipeline fork register. One upstream valid/data/stall channel is
//            held in a single register and offered to NOUT downstream
//            channels. Each consumer takes the token independently. The
//            stage remembers which outputs have been served, so no consumer
//            sees the same token twice. The stage frees itself only after
//            every enabled output has taken the token.
//
// Ports    : clk      - clock, rising edge
//            reset    - asynchronous active-high reset
//            v_i      - upstream token valid
//            data_i   - upstream token data [WIDTH-1:0]
//            stall_o  - upstream stall; producer holds v_i/data_i while high
//            v_o      - per-output valid [NOUT-1:0]
//            data_o   - output data [NOUT*WIDTH-1:0]; slice k is
//                       [k*WIDTH +: WIDTH], and every slice carries the held
//                       data
//            stall_i  - per-output downstream stall [NOUT-1:0]
//            mask_i   - destination mask [NOUT-1:0]; only present when
//                       FORK_STAGE_MASK_EN is defined
//
// Options  : FORK_STAGE_MASK_EN - when defined, adds mask_i. On load,
//            outputs whose mask bit is clear are marked as already served.
//            When undefined, every token is broadcast to all NOUT outputs.
//
// Revision : 1.0 - initial release
// ============================================================================
module fork_stage #(
    parameter int WIDTH = 32,
    parameter int NOUT  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  v_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic                  stall_o,
    output logic [NOUT-1:0]       v_o,
    output logic [NOUT*WIDTH-1:0] data_o,
`ifdef FORK_STAGE_MASK_EN
    input  logic [NOUT-1:0]       mask_i,
`endif
    input  logic [NOUT-1:0]       stall_i
);

    logic             r_v;
    logic [WIDTH-1:0] r_data;
    logic [NOUT-1:0]  r_done;

    logic [NOUT-1:0]  w_acc;
    logic             w_complete;
    logic [NOUT-1:0]  w_load_done;

    // An output that has already been served drops its valid. Its stall_i
    // then has no effect on the stage.
    assign v_o   = {NOUT{r_v}} & ~r_done;
    assign w_acc = v_o & ~stall_i;

    // The token is finished once every output has either been served earlier
    // or is accepting now. This lets a new token load in the same cycle that
    // the last pending consumer accepts, so no bubble is inserted.
    assign w_complete = &(r_done | w_acc);
    assign stall_o    = r_v & ~w_complete;

`ifdef FORK_STAGE_MASK_EN
    // Outputs outside the mask are treated as already served. An all-zero
    // mask therefore occupies the stage for one cycle and then drops the
    // token.
    assign w_load_done = ~mask_i;
`else
    assign w_load_done = '0;
`endif

    generate
        for (genvar k = 0; k < NOUT; k++) begin : g_slice
            assign data_o[k*WIDTH +: WIDTH] = r_data;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v    <= 1'b0;
            r_data <= '0;
            r_done <= '0;
        end else if (!stall_o) begin
            // Load a new token or a bubble. When v_i is low the data is
            // don't-care, but it still loads.
            r_v    <= v_i;
            r_data <= data_i;
            r_done <= w_load_done;
        end else begin
            r_done <= r_done | w_acc;
        end
    end

endmodule
`default_nettype wire
